// File: rtl/tick_trigger.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_trigger
//
// Free-running periodic trigger generator for an HC-SR04 style ultrasonic
// range sensor. The system clock is divided down to a timebase tick
// (1 us by default). A fixed-width high pulse is emitted on trigger_tick
// once per measurement period. There is no enable and no handshake: the
// block starts on its own when rst is released.
//
// Ports:
//   clk          in   1  system clock, all state changes on its rising edge
//   rst          in   1  asynchronous active-low reset
//   trigger_tick out  1  registered trigger pulse, drives the sensor TRIG pin
//   o_dbg_state  out  2  current FSM state (0 IDLE, 1 HIGH, 2 LOW)
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency
//   TICK_HZ      timebase rate; DIV = CLK_FREQ_HZ / TICK_HZ clocks per tick
//   PULSE_US     trigger high time in timebase ticks
//   PERIOD_US    rising edge to rising edge period in timebase ticks
// -----------------------------------------------------------------------------
module tick_trigger #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1_000_000,
   parameter int PULSE_US    = 10,
   parameter int PERIOD_US   = 60_000
) (
   input  logic       clk,
   input  logic       rst,
   output logic       trigger_tick,
   output logic [1:0] o_dbg_state
);

   localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int US_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

   // Refuse to build a block whose timing cannot be honoured.
   if (DIV < 2) begin : g_bad_div
      $error("tick_trigger: CLK_FREQ_HZ / TICK_HZ must be at least 2");
   end
   if (PULSE_US < 1) begin : g_bad_pulse
      $error("tick_trigger: PULSE_US must be at least 1");
   end
   if (PERIOD_US <= PULSE_US) begin : g_bad_period
      $error("tick_trigger: PERIOD_US must be greater than PULSE_US");
   end

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
   localparam logic [US_W-1:0]  PULSE_LAST = US_W'(PULSE_US - 1);
   // Low phase length is the rest of the period after the high phase.
   localparam logic [US_W-1:0]  LOW_LAST   = US_W'(PERIOD_US - PULSE_US - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   state_t            r_state;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [US_W-1:0]   r_us_cnt;
   logic              r_trigger;
   logic              w_tick_1us;

   // ---------------------------------------------------------------------
   // Prescaler: counts 0..DIV-1 and wraps. The timebase tick is the last
   // clock of each prescaler cycle, so the first tick after reset lands on
   // clock DIV-1 and the FSM reacts on clock DIV.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   assign w_tick_1us = (r_div_cnt == DIV_LAST);

   // ---------------------------------------------------------------------
   // Trigger FSM. r_us_cnt counts timebase ticks spent in the current
   // state and is cleared on every state change, so each phase lasts an
   // exact number of ticks and the period never drifts.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_us_cnt  <= '0;
         r_trigger <= 1'b0;
      end else if (w_tick_1us) begin
         case (r_state)
            S_IDLE: begin
               r_state   <= S_HIGH;
               r_us_cnt  <= '0;
               r_trigger <= 1'b1;
            end
            S_HIGH: begin
               if (r_us_cnt == PULSE_LAST) begin
                  r_state   <= S_LOW;
                  r_us_cnt  <= '0;
                  r_trigger <= 1'b0;
               end else begin
                  r_us_cnt  <= r_us_cnt + US_W'(1);
               end
            end
            S_LOW: begin
               if (r_us_cnt == LOW_LAST) begin
                  r_state   <= S_HIGH;
                  r_us_cnt  <= '0;
                  r_trigger <= 1'b1;
               end else begin
                  r_us_cnt  <= r_us_cnt + US_W'(1);
               end
            end
            default: begin
               // Unused encoding: fall back to a clean restart.
               r_state   <= S_IDLE;
               r_us_cnt  <= '0;
               r_trigger <= 1'b0;
            end
         endcase
      end
   end

   assign trigger_tick = r_trigger;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_tick_trigger.sv
`timescale 1ns/1ps
module tb_tick_trigger;

  localparam logic [1:0] ST_IDLE = 2'd0;

  logic       clk;
  logic       rst_d;
  logic       rst_o;
  logic       trig_d;
  logic       trig_o;
  logic [1:0] st_d;
  logic [1:0] st_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Default parameters: DIV = 100, PULSE_US = 10, PERIOD_US = 60000.
  tick_trigger u_def (
    .clk          (clk),
    .rst          (rst_d),
    .trigger_tick (trig_d),
    .o_dbg_state  (st_d)
  );

  // Small override: DIV = 4, PULSE_US = 2, PERIOD_US = 5.
  tick_trigger #(
    .CLK_FREQ_HZ (4),
    .TICK_HZ     (1),
    .PULSE_US    (2),
    .PERIOD_US   (5)
  ) u_ovr (
    .clk          (clk),
    .rst          (rst_o),
    .trigger_tick (trig_o),
    .o_dbg_state  (st_o)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge (sampling point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected default-DUT output after edge e counted from reset release.
  function automatic logic exp_def(int e);
    return (e >= 100) && (e < 1100);
  endfunction

  // Expected override output: rise at edge 4, high 8 clks, period 20 clks.
  function automatic logic exp_ovr(int e);
    if (e < 4) return 1'b0;
    return ((e - 4) % 20) < 8;
  endfunction

  // -------------------------------------------------------------- tests
  // Reset held from time 0, released at 10 ns (a falling edge).
  task automatic test_reset();
    #2;
    tests_run++;
    if (trig_d !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_trig: got %b want 0", trig_d);
    end
    tests_run++;
    if (st_d !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", st_d, ST_IDLE);
    end
    #8;
    rst_d = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      tests_run++;
      if (trig_d !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_first10 edge %0d: got %b want 0", e, trig_d);
      end
    end
  endtask

  // Continues counting from edge 11 of the default DUT.
  task automatic test_default_timing();
    for (int e = 11; e <= 1200; e++) begin
      step();
      tests_run++;
      if (trig_d !== exp_def(e)) begin
        tests_failed++;
        $display("FAIL default_timing edge %0d: got %b want %b", e, trig_d, exp_def(e));
      end
    end
  endtask

  // The override DUT has been in reset since time 0.
  task automatic test_hold_reset();
    for (int e = 0; e < 50; e++) begin
      step();
      tests_run++;
      if (trig_o !== 1'b0 || st_o !== ST_IDLE) begin
        tests_failed++;
        $display("FAIL hold_reset cycle %0d: trig %b state %0d want 0/%0d", e, trig_o, st_o, ST_IDLE);
      end
    end
    // Release in the middle of a clock period.
    #2;
    rst_o = 1'b1;
  endtask

  // Periodic waveform for at least 5 full periods, counted from release.
  task automatic test_override_periodic();
    for (int e = 1; e <= 110; e++) begin
      step();
      tests_run++;
      if (trig_o !== exp_ovr(e)) begin
        tests_failed++;
        $display("FAIL ovr_periodic edge %0d: got %b want %b", e, trig_o, exp_ovr(e));
      end
    end
  endtask

  // Edge 110 ended above; edges 111..127 bring us to (e-4)%20 == 3 (high).
  task automatic test_async_reset_mid_pulse();
    for (int e = 111; e <= 127; e++) begin
      step();
    end
    tests_run++;
    if (trig_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pulse_precond: got %b want 1", trig_o);
    end
    #2;
    rst_o = 1'b0;
    #1;
    // Still before the next edge: the drop must be asynchronous.
    tests_run++;
    if (trig_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_drop: got %b want 0", trig_o);
    end
    tests_run++;
    if (st_o !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL async_state: got %0d want %0d", st_o, ST_IDLE);
    end
    for (int e = 0; e < 3; e++) begin
      step();
    end
    #2;
    rst_o = 1'b1;
  endtask

  // After the mid-pulse reset the sequence restarts with the same latency.
  task automatic test_back_to_back();
    for (int e = 1; e <= 30; e++) begin
      step();
      tests_run++;
      if (trig_o !== exp_ovr(e)) begin
        tests_failed++;
        $display("FAIL restart edge %0d: got %b want %b", e, trig_o, exp_ovr(e));
      end
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst_d = 1'b0;
    rst_o = 1'b0;
    test_reset();
    test_default_timing();
    test_hold_reset();
    test_override_periodic();
    test_async_reset_mid_pulse();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tick_trigger.md
Name: tick_trigger

Overview:
- Free-running periodic trigger generator for the ultrasonic range-sensor path (HC-SR04 style).
- Divides the system clock down to a 1 us timebase.
- Emits a fixed-width high pulse on trigger_tick once per measurement period.
- Drives the sensor TRIG pin directly and runs unconditionally after reset; no enable or handshake.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1_000_000, internal timebase rate; DIV = CLK_FREQ_HZ / TICK_HZ clocks per tick (default 100).
- PULSE_US, 10, trigger high time in timebase ticks.
- PERIOD_US, 60_000, full trigger period (rising edge to rising edge) in timebase ticks.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately, independent of clk.
- trigger_tick  output  1  registered trigger pulse; high for PULSE_US ticks once every PERIOD_US ticks.

Behaviour:
- Interface: one clock domain (clk). rst is asynchronous and active-low. No other inputs.
- Legal parameters: DIV >= 2, PULSE_US >= 1, PERIOD_US > PULSE_US. Elaboration-time check (error/$fatal) if violated.
- Prescaler:
  - div_cnt width $clog2(DIV); counts 0..DIV-1 and wraps to 0.
  - tick_1us is internal, combinational, high while div_cnt == DIV-1 (one clk every DIV clks).
- Tick counter:
  - us_cnt width $clog2(PERIOD_US); counts timebase ticks within the current state.
  - Cleared on every state change.
- FSM states:
  - IDLE (reset state): on first tick_1us go to HIGH, trigger_tick <= 1, us_cnt <= 0.
  - HIGH: on each tick_1us, us_cnt increments. On the tick where us_cnt == PULSE_US-1, go to LOW, trigger_tick <= 0, us_cnt <= 0.
  - LOW: on each tick_1us, us_cnt increments. On the tick where us_cnt == PERIOD_US-PULSE_US-1, go to HIGH, trigger_tick <= 1, us_cnt <= 0.
- Timing:
  - First rising edge of trigger_tick: at the DIV-th rising clk edge after rst deasserts (edge 100 by default). It stays 0 for the first DIV-1 edges.
  - High time exactly PULSE_US*DIV clks (1000 by default).
  - Period exactly PERIOD_US*DIV clks (6_000_000 by default), no drift.
- trigger_tick is a flop output; no combinational path to the port.
- Reset:
  - rst = 0 forces div_cnt = 0, us_cnt = 0, state = IDLE, trigger_tick = 0 asynchronously, including mid-pulse.
  - After release the sequence restarts from IDLE with the same first-edge latency.
- Wrap: counters never exceed their terminal values; no overflow states. Unreachable FSM encodings recover to IDLE.

Test Plan:
- Defaults, rst = 0 for 10 ns then 1, run 10 clks -> trigger_tick = 0 throughout.
- Defaults, after release count edges -> trigger_tick rises at edge 100, stays high 1000 clks, next rise 6_000_000 clks after the first.
- Override DIV = 4 (CLK_FREQ_HZ = 4, TICK_HZ = 1), PULSE_US = 2, PERIOD_US = 5 -> first rise at edge 4, high 8 clks, low 12 clks, repeats every 20 clks for at least 5 periods.
- Same override, assert rst mid-pulse (between clk edges) -> trigger_tick drops to 0 immediately without a clk edge. After release, first rise again at edge 4.
- Same override, hold rst low across many clks -> trigger_tick = 0 and no internal counting. Release mid clock period -> timing measured from the first rising edge after release.
- Illegal parameters (PULSE_US = PERIOD_US) -> elaboration fails.
